// File: rtl/pad_tx_serializer.sv
// Pad-side serializer: parallel word in, LSB-first serial out with lead/trail idle framing.
// Optional odd-parity bit appended when PAD_TX_PARITY_EN is defined.
module pad_tx_serializer #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned LEAD_CYC  = 2,
    parameter int unsigned TRAIL_CYC = 2,
    parameter logic        IDLE_LVL  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              dout_p,
    output logic              dout_n,
    output logic              oen,
    output logic              busy
);

`ifdef PAD_TX_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif
    localparam int unsigned NBITS = DATA_W + PAR_W;
    localparam int unsigned BIT_W = $clog2(NBITS + 1);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT,
        S_TRAIL
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [NBITS-1:0]   sh_q, sh_d;
    logic               dout_q, dout_d;
    logic               oen_q, oen_d;
    logic               busy_q, busy_d;
    logic [NBITS-1:0]   word_c;
    logic               last_bit_c;
    logic               hs_c;

    // Word as it goes on the line; parity (if present) rides as the final bit.
`ifdef PAD_TX_PARITY_EN
    assign word_c = {~(^tx_data), tx_data};
`else
    assign word_c = tx_data;
`endif

    assign last_bit_c = (bit_q == BIT_W'(NBITS - 1));
    assign tx_ready   = (state_q == S_IDLE) || (state_q == S_TRAIL) ||
                        ((state_q == S_SHIFT) && last_bit_c);
    assign hs_c       = tx_valid && tx_ready;

    assign dout_p = dout_q;
    assign dout_n = ~dout_q;
    assign oen    = oen_q;
    assign busy   = busy_q;

    // Next-state and next-output decode; outputs follow the state being entered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        case (state_q)
            S_IDLE: begin
                if (hs_c) begin
                    state_d = S_LEAD;
                    sh_d    = word_c;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            S_LEAD: begin
                if (cnt_q == CNT_W'(LEAD_CYC - 1)) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                if (last_bit_c) begin
                    bit_d = '0;
                    cnt_d = '0;
                    if (hs_c) begin
                        sh_d = word_c;
                    end else begin
                        state_d = S_TRAIL;
                    end
                end else begin
                    sh_d  = sh_q >> 1;
                    bit_d = bit_q + BIT_W'(1);
                end
            end
            S_TRAIL: begin
                if (hs_c) begin
                    // Chain straight into the next word; the trail is abandoned.
                    state_d = S_SHIFT;
                    sh_d    = word_c;
                    bit_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TRAIL_CYC - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        dout_d = (state_d == S_SHIFT) ? sh_d[0] : IDLE_LVL;
        oen_d  = (state_d == S_IDLE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            dout_q  <= IDLE_LVL;
            oen_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            oen_q   <= oen_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: doc/pad_tx_serializer.md
PAD_TX_SERIALIZER -- requirements
Module: pad_tx_serializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning serial word width in bits (legal 2..16).
REQ-002 The block SHALL have parameter LEAD_CYC, default 2, meaning idle-level cycles driven after OEN asserts and before the first bit (legal 1..15).
REQ-003 The block SHALL have parameter TRAIL_CYC, default 2, meaning idle-level cycles driven after the last bit before OEN releases (legal 1..15).
REQ-004 The block SHALL have parameter IDLE_LVL, default 1'b1, meaning the line level driven when no bit is being sent.
REQ-005 The block SHALL have one clock; reset is synchronous and active-low; ports in order: clk, rst_n.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 tx_data  input  DATA_W  parallel word, sampled only on handshake.
REQ-009 tx_valid  input  1  word offered.
REQ-010 tx_ready  output  1  word accepted when tx_valid and tx_ready are high on the same edge.
REQ-011 dout_p  output  1  serial data to pad I pin, LSB first.
REQ-012 dout_n  output  1  complement of dout_p every cycle, for the differential pair.
REQ-013 oen  output  1  active-low pad output enable (0 = pad driven, 1 = tristate).
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 All outputs except tx_ready SHALL be registered; tx_ready SHALL be decoded from registered state only, never from tx_valid.
REQ-016 States SHALL be IDLE, LEAD, SHIFT, TRAIL.
REQ-017 tx_ready SHALL be high in IDLE, in TRAIL, and in the last SHIFT cycle of a word; low otherwise.
REQ-018 IDLE: oen=1, dout_p=IDLE_LVL; a handshake loads the shift register and moves to LEAD, with oen=0 from the next cycle.
REQ-019 LEAD: dout_p=IDLE_LVL, oen=0 for exactly LEAD_CYC cycles, then SHIFT.
REQ-020 SHIFT: data bit k SHALL appear on dout_p in SHIFT cycle k (k=0..DATA_W-1), one bit per clock.
REQ-021 A handshake on the last SHIFT cycle SHALL put bit 0 of the new word on dout_p in the following cycle, with no idle gap and no LEAD.
REQ-022 The last SHIFT cycle without a handshake SHALL go to TRAIL.
REQ-023 TRAIL: dout_p=IDLE_LVL, oen=0 for TRAIL_CYC cycles, then IDLE with oen=1.
REQ-024 A handshake in TRAIL SHALL go directly to SHIFT (no LEAD; oen stays 0); the trail counter SHALL be discarded.
REQ-025 tx_valid held high while tx_ready is low SHALL not alter the word in flight; tx_data changes outside a handshake SHALL be ignored.
REQ-026 Bit and lead/trail counters SHALL be sized to hold DATA_W and 15 respectively, with no wrap inside a word.

Reset
REQ-027 While rst_n=0 at a clock edge, next state SHALL be IDLE with oen=1, dout_p=IDLE_LVL, dout_n=~IDLE_LVL, busy=0, tx_ready=1, counters and shift register zero.
REQ-028 Reset in any state mid-word SHALL drop the word in flight; no partial bits after the reset edge.

Configuration
REQ-029 Macro PAD_TX_PARITY_EN SHALL, when defined, add one SHIFT cycle after bit DATA_W-1 carrying odd parity of the word (XOR of all bits, inverted); the parity cycle becomes the last SHIFT cycle for REQ-017/021/022.
REQ-030 Without PAD_TX_PARITY_EN, a word SHALL occupy exactly DATA_W SHIFT cycles and no parity logic SHALL be present.

Verification
REQ-031 Single word: default params, send 8'hA5 after reset -> oen low 2 cycles idle (1), then dout_p 1,0,1,0,0,1,0,1, then 2 idle cycles, then oen=1; dout_n always inverse.
REQ-032 Back-to-back: 8'h0F then 8'hF0 offered continuously -> 16 consecutive data bits 1111000000001111, one LEAD, one TRAIL, tx_ready high only on cycles 8 and 16 of SHIFT.
REQ-033 Accept in TRAIL: 8'h01 sent, 8'h80 offered in 1st TRAIL cycle -> 1 idle cycle, then bits 00000001, oen never deasserts.
REQ-034 Reset mid-word: rst_n=0 during SHIFT bit 3 of 8'hFF -> next cycle oen=1, dout_p=1, busy=0, tx_ready=1; no later data bits.
REQ-035 Parity build: PAD_TX_PARITY_EN defined, send 8'h03 -> 9 SHIFT cycles, 9th bit = 1; send 8'h07 -> 9th bit = 0.
REQ-036 Stall: tx_valid high with tx_data changing every cycle during SHIFT of 8'h3C -> transmitted bits remain 00111100.
